hazard_stall_ctrl: RTL

- Pipeline control block sitting beside the operand-forwarding unit in the 5-stage ARM core.
- Consumes the forwarding unit's ignore_hazard, the ID-stage source registers and the EXE/MEM destination tags. Decides each cycle whether to freeze the front end, inject a bubble into ID/EXE, flush on a taken branch, or freeze the whole pipe while the SRAM controller is busy.
- Contains the memory-wait FSM with timeout and saturating performance counters.

---
 rtl/hazard_stall_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline control for the 5-stage ARM core. It sits beside the operand
//   forwarding unit and decides each cycle whether to freeze the front end,
//   inject a bubble into ID/EXE, flush IF/ID on a taken branch, or freeze the
//   whole pipe while the SRAM controller is busy. A memory wait that lasts too
//   long is latched as a sticky timeout. Saturating counters record stall and
//   memory-wait cycles.
//
// Ports
//   clk, rst                     core clock, synchronous active-high reset
//   forward_en, ignore_hazard    forwarding unit state / MEM-WB bypass covers ID
//   ID_src1/2, ID_use_src1/2     ID-stage source registers and their use bits
//   EXE_dst, EXE_wb_en,
//   EXE_mem_read                 EXE-stage destination tag, write-back, load
//   MEM_dst, MEM_wb_en           MEM-stage destination tag, write-back
//   MEM_mem_req, mem_ready       MEM stage memory access / SRAM done
//   branch_taken                 taken branch resolved in EXE
//   freeze_front, bubble_id_exe,
//   flush_if_id, freeze_all      combinational pipeline controls
//   mem_timeout                  sticky memory timeout flag
//   stall_cycles, wait_cycles    saturating performance counters
module hazard_stall_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic             ignore_hazard,
    input  logic [3:0]       ID_src1,
    input  logic [3:0]       ID_src2,
    input  logic             ID_use_src1,
    input  logic             ID_use_src2,
    input  logic [3:0]       EXE_dst,
    input  logic             EXE_wb_en,
    input  logic             EXE_mem_read,
    input  logic [3:0]       MEM_dst,
    input  logic             MEM_wb_en,
    input  logic             MEM_mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             freeze_front,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] wait_cycles
);

    localparam int unsigned WCNT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCNT_W:0] WAIT_LIMIT = (WCNT_W + 1)'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W:0]   wait_cnt_inc;

    logic raw_exe;
    logic raw_mem;
    logic haz;
    logic mem_block;
    logic run_eval;
    logic stall_inc;
    logic wait_inc;

    always_comb begin
        raw_exe = EXE_wb_en & ((ID_use_src1 & (EXE_dst == ID_src1)) |
                               (ID_use_src2 & (EXE_dst == ID_src2)));
        raw_mem = MEM_wb_en & ((ID_use_src1 & (MEM_dst == ID_src1)) |
                               (ID_use_src2 & (MEM_dst == ID_src2)));
        if (forward_en)
            // Load-use always stalls; other RAW stalls only when no bypass covers it.
            haz = (raw_exe & EXE_mem_read) |
                  ((raw_exe | raw_mem) & ~ignore_hazard & ~EXE_mem_read);
        else
            haz = raw_exe | raw_mem;
        mem_block    = MEM_mem_req & ~mem_ready;
        wait_cnt_inc = {1'b0, wait_cnt} + (WCNT_W + 1)'(1);
    end

    // Controls are Mealy: the release cycle of MEM_WAIT re-runs the normal
    // RUN priority on that same cycle's inputs.
    always_comb begin
        freeze_front  = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        freeze_all    = 1'b0;
        stall_inc     = 1'b0;
        wait_inc      = 1'b0;
        run_eval      = 1'b0;
        case (state)
            RUN: run_eval = 1'b1;
            MEM_WAIT: begin
                if (mem_ready) begin
                    run_eval = 1'b1;
                end else begin
                    freeze_all = 1'b1;
                    wait_inc   = 1'b1;
                end
            end
            TIMEOUT: freeze_all = 1'b1;
            default: freeze_all = 1'b1;
        endcase
        if (run_eval) begin
            if (mem_block) begin
                freeze_all = 1'b1;
                wait_inc   = 1'b1;
            end else if (branch_taken) begin
                flush_if_id   = 1'b1;
                bubble_id_exe = 1'b1;
            end else if (haz) begin
                freeze_front  = 1'b1;
                bubble_id_exe = 1'b1;
                stall_inc     = 1'b1;
            end
        end
        if (rst) begin
            freeze_front  = 1'b0;
            bubble_id_exe = 1'b0;
            flush_if_id   = 1'b0;
            freeze_all    = 1'b0;
            stall_inc     = 1'b0;
            wait_inc      = 1'b0;
        end
    end

    assign mem_timeout = (state == TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            wait_cycles  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_block) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt_inc[WCNT_W-1:0];
                        if (wait_cnt_inc >= WAIT_LIMIT)
                            state <= TIMEOUT;
                    end
                end
                TIMEOUT: state <= TIMEOUT;
                default: state <= RUN;
            endcase
            if (stall_inc && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (wait_inc && (wait_cycles != '1))
                wait_cycles <= wait_cycles + CNT_W'(1);
        end
    end

endmodule
